mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage that sits directly downstream of the execute stage.
- Registers the EX→MEM instruction bus and holds it under stall. Flush or bubble invalidates it.
- Captures the synchronous data-SRAM read data and holds it across stalls, then aligns and extends load data.
- Produces the MEM→WB bus and the MEM→ID forwarding bus.

Parameters:
- EX_BUS_W, 195: width of ex_to_mem_bus; must equal `EX_INST_INFO.
- WB_BUS_W, 180: width of mem_to_wb_bus.
- FWD_BUS_W, 104: width of mem_to_rf_bus.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction entering or held in MEM (exception/eret)
- stall_mem  in  1  hold the MEM register contents this cycle
- stall_ex  in  1  EX is stalled; if ~stall_mem, insert a bubble into MEM
- ex_to_mem_bus  in  EX_BUS_W  {exceptinfo[43:0], mem_op[7:0], hilo_bus[65:0], pc[31:0], ram_en, ram_wen, ram_sel[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the address is issued
- mem_to_wb_bus  out  WB_BUS_W  {exceptinfo[43:0], hilo_bus[65:0], pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}
- mem_to_rf_bus  out  FWD_BUS_W  {hilo_bus[65:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}
- mem_valid  out  1  MEM register holds a live instruction

Behaviour:
- Reset (resetn low, async): pipeline register, valid, rdata buffer and buf_valid all cleared to 0. All outputs are therefore 0.
- Register update, evaluated each posedge, first match wins:
  1. flush: valid←0, register←0.
  2. stall_mem: hold.
  3. stall_ex: bubble (valid←0, register←0).
  4. otherwise: register←ex_to_mem_bus, valid←1.
- first_cycle flag: set on any cycle the register loads a new instruction; cleared on the next edge.
- Read-data capture: data_sram_rdata is only guaranteed during first_cycle.
  - If first_cycle & stall_mem: rdata_buf←data_sram_rdata, buf_valid←1.
  - buf_valid clears when the register loads, bubbles or flushes.
  - Effective rdata = buf_valid ? rdata_buf : data_sram_rdata.
- Load alignment, selected by mem_op {lb, lbu, lh, lhu, lw, sb, sh, sw} and a = ex_result[1:0]:
  - lb / lbu: byte rdata[8a+7:8a], sign-extended / zero-extended.
  - lh / lhu: half rdata[16a1+15:16a1], where a1 = a[1], sign-/zero-extended.
  - lw: rdata unchanged.
  - Misaligned lh/lw never reach here as live writes (EX flags ADEL); the data path ignores a[0] for halfwords.
- rf_wdata = sel_rf_res ? aligned_load : ex_result.
- Write gating: when valid==0 or exceptinfo[31:0]!=0, gate rf_we and both hilo write enables (hilo_bus bits 65 and 32) to 0. Pass exceptinfo unchanged.
- Outputs are combinational from the register plus effective rdata. Latency from ex_to_mem_bus to mem_to_wb_bus is 1 cycle.
- mem_to_rf_bus uses the same gated fields as mem_to_wb_bus, so ID forwarding never sees a killed write.
- Simultaneous flush+stall_mem: flush wins.
- Reset mid-load: buffer discarded, no write emitted.

Decomposition:
- Shared defines file holds:
  - bus widths (`EX_INST_INFO, `MEM_TO_WB_WD, `MEM_TO_RF_WD);
  - mem_op bit indices;
  - the exceptinfo[31:0] exception-code constants.
- One sub-module, load_align: combinational {mem_op, addr[1:0], rdata} → aligned 32-bit data. It is reusable by a future cache path.

Test Plan:
- lb at ex_result=0x1003, rdata=0x80FF_1234, no stall → next cycle rf_wdata=0xFFFF_FF80, rf_we=1. Repeat with lbu → 0x0000_0080.
- lh at addr 0x2002, rdata=0x8001_7FFF, stall_mem held 3 cycles, SRAM rdata changed to 0xDEAD_BEEF after the first cycle → rf_wdata stays 0xFFFF_8001 throughout and after release.
- flush asserted together with stall_mem while a lw (rf_we=1) is in MEM → mem_valid=0 next cycle; mem_to_wb_bus and mem_to_rf_bus equal 0.
- stall_ex=1, stall_mem=0 for 2 cycles behind an addu → MEM shows the addu once, then 2 bubbles (rf_we=0), then the stalled instruction.
- mult result hilo_bus with hi_we=lo_we=1 and exceptinfo[31:0]=OV code → both hilo enables and rf_we forced to 0; exceptinfo passed through bit-exact.
- resetn pulsed low asynchronously mid-cycle during a buffered load → outputs go to 0 immediately; buf_valid=0 after release.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts, mem_op bit positions and exception codes for the MEM stage.
package mem_stage_pkg;

  localparam int EX_INST_INFO = 195;
  localparam int MEM_TO_WB_WD = 180;
  localparam int MEM_TO_RF_WD = 104;

  // mem_op bit positions, {lb, lbu, lh, lhu, lw, sb, sh, sw}
  localparam int OP_LB  = 7;
  localparam int OP_LBU = 6;
  localparam int OP_LH  = 5;
  localparam int OP_LHU = 4;
  localparam int OP_LW  = 3;
  localparam int OP_SB  = 2;
  localparam int OP_SH  = 1;
  localparam int OP_SW  = 0;

  // exceptinfo[31:0] one-hot cause flags; any nonzero value kills the writeback
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0002;
  localparam logic [31:0] EXC_ADES = 32'h0000_0004;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0010;
  localparam logic [31:0] EXC_RI   = 32'h0000_0020;
  localparam logic [31:0] EXC_OV   = 32'h0000_0040;
  localparam logic [31:0] EXC_ERET = 32'h0000_0080;

  localparam int HI_WE_BIT = 65;
  localparam int LO_WE_BIT = 32;

  typedef struct packed {
    logic [43:0] exceptinfo;
    logic [7:0]  mem_op;
    logic [65:0] hilo_bus;
    logic [31:0] pc;
    logic        ram_en;
    logic        ram_wen;
    logic [3:0]  ram_sel;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_bus_t;

  typedef struct packed {
    logic [43:0] exceptinfo;
    logic [65:0] hilo_bus;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } wb_bus_t;

  typedef struct packed {
    logic [65:0] hilo_bus;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } rf_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM control/data inputs and MEM->WB / MEM->ID outputs of the memory stage.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int EX_BUS_W  = EX_INST_INFO,
  parameter int WB_BUS_W  = MEM_TO_WB_WD,
  parameter int FWD_BUS_W = MEM_TO_RF_WD
);
  logic                 flush;
  logic                 stall_mem;
  logic                 stall_ex;
  logic [EX_BUS_W-1:0]  ex_to_mem_bus;
  logic [31:0]          data_sram_rdata;
  logic [WB_BUS_W-1:0]  mem_to_wb_bus;
  logic [FWD_BUS_W-1:0] mem_to_rf_bus;
  logic                 mem_valid;

  modport master (
    output flush, stall_mem, stall_ex, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_rf_bus, mem_valid
  );

  modport slave (
    input  flush, stall_mem, stall_ex, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_rf_bus, mem_valid
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load-data alignment: picks the addressed byte/half/word and extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_store_ops;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  // halfword lane ignores addr[0]; misaligned halves are trapped upstream
  assign half_sel = rdata[{addr[1], 4'b0000} +: 16];
  assign unused_store_ops = ^mem_op[OP_SB:OP_SW];

  always_comb begin
    data = '0;
    if (mem_op[OP_LB])       data = sext8(byte_sel);
    else if (mem_op[OP_LBU]) data = {24'd0, byte_sel};
    else if (mem_op[OP_LH])  data = sext16(half_sel);
    else if (mem_op[OP_LHU]) data = {16'd0, half_sel};
    else if (mem_op[OP_LW])  data = rdata;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX->MEM register, SRAM read-data hold buffer, load alignment, WB/ID buses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EX_BUS_W  = EX_INST_INFO,
  parameter int WB_BUS_W  = MEM_TO_WB_WD,
  parameter int FWD_BUS_W = MEM_TO_RF_WD
)(
  input logic       clk,
  input logic       resetn,
  mem_stage_if.slave bus
);

  logic [EX_BUS_W-1:0] ex_bus_p1;
  logic                vld_p1;
  logic                first_p1;
  logic                buf_vld_p1;
  logic [31:0]         rdata_buf_p1;

  // Stage p1: MEM register, first-cycle flag and read-data capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_bus_p1    <= '0;
      vld_p1       <= 1'b0;
      first_p1     <= 1'b0;
      buf_vld_p1   <= 1'b0;
      rdata_buf_p1 <= '0;
    end else begin
      first_p1 <= 1'b0;
      if (bus.flush) begin
        ex_bus_p1  <= '0;
        vld_p1     <= 1'b0;
        buf_vld_p1 <= 1'b0;
      end else if (bus.stall_mem) begin
        // SRAM data is only guaranteed in the first MEM cycle; keep a copy for the hold
        if (first_p1) begin
          rdata_buf_p1 <= bus.data_sram_rdata;
          buf_vld_p1   <= 1'b1;
        end
      end else if (bus.stall_ex) begin
        ex_bus_p1  <= '0;
        vld_p1     <= 1'b0;
        buf_vld_p1 <= 1'b0;
      end else begin
        ex_bus_p1  <= bus.ex_to_mem_bus;
        vld_p1     <= 1'b1;
        first_p1   <= 1'b1;
        buf_vld_p1 <= 1'b0;
      end
    end
  end

  // Stage p1 outputs: align, gate and pack
  ex_bus_t     ex;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic [65:0] hilo_gated;
  logic        kill;
  logic        unused_ram;
  wb_bus_t     wb;
  rf_bus_t     fwd;

  assign ex        = ex_bus_t'(ex_bus_p1);
  assign rdata_eff = buf_vld_p1 ? rdata_buf_p1 : bus.data_sram_rdata;

  load_align u_load_align (
    .mem_op (ex.mem_op),
    .addr   (ex.ex_result[1:0]),
    .rdata  (rdata_eff),
    .data   (load_data)
  );

  assign kill     = !vld_p1 || (ex.exceptinfo[31:0] != 32'd0);
  assign rf_wdata = ex.sel_rf_res ? load_data : ex.ex_result;

  always_comb begin
    hilo_gated = ex.hilo_bus;
    hilo_gated[HI_WE_BIT] = ex.hilo_bus[HI_WE_BIT] & ~kill;
    hilo_gated[LO_WE_BIT] = ex.hilo_bus[LO_WE_BIT] & ~kill;
  end

  assign wb.exceptinfo = ex.exceptinfo;
  assign wb.hilo_bus   = hilo_gated;
  assign wb.pc         = ex.pc;
  assign wb.rf_we      = ex.rf_we & ~kill;
  assign wb.rf_waddr   = ex.rf_waddr;
  assign wb.rf_wdata   = rf_wdata;

  // forwarding sees exactly the gated writeback fields
  assign fwd.hilo_bus  = wb.hilo_bus;
  assign fwd.rf_we     = wb.rf_we;
  assign fwd.rf_waddr  = wb.rf_waddr;
  assign fwd.rf_wdata  = wb.rf_wdata;

  assign unused_ram = ^{ex.ram_en, ex.ram_wen, ex.ram_sel};

  assign bus.mem_to_wb_bus = WB_BUS_W'(wb);
  assign bus.mem_to_rf_bus = FWD_BUS_W'(fwd);
  assign bus.mem_valid     = vld_p1;

endmodule
